// File: rtl/snake_score_overlay.sv
// snake_score_overlay: keeps a 3-digit BCD snake score and draws it as white seven-segment digits over the renderer output.
// Define SNAKE_SCORE_HIGH_EN to add a high-score register, a high_bcd port and a second, non-blinking digit row.
module snake_score_overlay #(
   parameter int DIGIT_X0  = 560,
   parameter int DIGIT_Y0  = 20,
   parameter int V_ACTIVE  = 480,
   parameter int BLINK_BIT = 4
) (
   input  logic        VGA_clk,
   input  logic        reset,
   input  logic [10:0] x_count,
   input  logic [9:0]  y_count,
   input  logic        display_area,
   input  logic        h_sync_in,
   input  logic        v_sync_in,
   input  logic [3:0]  red_in,
   input  logic [3:0]  green_in,
   input  logic [3:0]  blue_in,
   input  logic        eat,
   input  logic        game_over,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        h_sync,
   output logic        v_sync,
   output logic [11:0] score_bcd,
`ifdef SNAKE_SCORE_HIGH_EN
   output logic [11:0] high_bcd,
`endif
   output logic        over
);
   typedef enum logic {RUN, OVER} state_t;
   state_t      r_state, w_state_next;
   logic        r_eat_seen;
   logic [7:0]  r_frame_cnt;
   logic [11:0] r_score, w_score_inc, w_score_next;
   logic        w_commit, w_show, w_lit;
   // segment vector ordered {a,b,c,d,e,f,g}
   function automatic logic [6:0] seg_dec(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1111110;
         4'd1:    return 7'b0110000;
         4'd2:    return 7'b1101101;
         4'd3:    return 7'b1111001;
         4'd4:    return 7'b0110011;
         4'd5:    return 7'b1011011;
         4'd6:    return 7'b1011111;
         4'd7:    return 7'b1110000;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction
   function automatic logic seg_hit(input logic [10:0] x, input logic [9:0] y, input int x0, input int y0, input logic [3:0] d);
      int cx, cy;
      logic [6:0] s;
      cx = int'(x) - x0;
      cy = int'(y) - y0;
      s  = seg_dec(d);
      return cx >= 0 && cx <= 15 && cy >= 0 && cy <= 23 &&
         ((s[6] && cy <= 2 && cx >= 2 && cx <= 13) ||
          (s[5] && cx >= 13 && cy >= 2 && cy <= 11) ||
          (s[4] && cx >= 13 && cy >= 13 && cy <= 21) ||
          (s[3] && cy >= 21 && cx >= 2 && cx <= 13) ||
          (s[2] && cx <= 2 && cy >= 13 && cy <= 21) ||
          (s[1] && cx <= 2 && cy >= 2 && cy <= 11) ||
          (s[0] && cy >= 11 && cy <= 13 && cx >= 2 && cx <= 13));
   endfunction
   assign w_commit     = x_count == 11'd0 && y_count == 10'(V_ACTIVE);
   assign w_show       = r_state == RUN || !r_frame_cnt[BLINK_BIT];
   assign w_score_inc  = r_score == 12'h999 ? r_score :
                         r_score[3:0] != 4'd9 ? {r_score[11:4], r_score[3:0] + 4'd1} :
                         r_score[7:4] != 4'd9 ? {r_score[11:8], r_score[7:4] + 4'd1, 4'd0} :
                         {r_score[11:8] + 4'd1, 8'd0};
   assign w_score_next = w_commit && r_eat_seen ? w_score_inc : r_score;
   always_comb begin
      w_state_next = r_state;
      if (r_state == RUN && w_commit && game_over) w_state_next = OVER;
   end
   always_ff @(posedge VGA_clk) begin
      if (reset) r_state <= RUN;
      else r_state <= w_state_next;
   end
`ifdef SNAKE_SCORE_HIGH_EN
   logic [11:0] r_high;
   // BCD digits compare in the same order as their binary encoding
   always_ff @(posedge VGA_clk) begin
      if (reset) r_high <= 12'h000;
      else if (r_state == RUN && w_state_next == OVER && w_score_next > r_high) r_high <= w_score_next;
   end
   assign high_bcd = r_high;
`endif
   always_comb begin
      w_lit = 1'b0;
      for (int k = 0; k < 3; k++) begin
         w_lit = w_lit | (w_show & seg_hit(x_count, y_count, DIGIT_X0 + 20 * k, DIGIT_Y0, r_score[11 - 4 * k -: 4]));
`ifdef SNAKE_SCORE_HIGH_EN
         w_lit = w_lit | seg_hit(x_count, y_count, DIGIT_X0 + 20 * k, DIGIT_Y0 + 30, r_high[11 - 4 * k -: 4]);
`endif
      end
   end
   always_ff @(posedge VGA_clk) begin
      if (reset) begin
         r_eat_seen  <= 1'b0;
         r_frame_cnt <= 8'd0;
         r_score     <= 12'h000;
         red         <= 4'h0;
         green       <= 4'h0;
         blue        <= 4'h0;
         h_sync      <= 1'b1;
         v_sync      <= 1'b1;
      end else begin
         // an eat on the commit cycle itself belongs to the next frame
         r_eat_seen  <= (r_state == OVER || w_state_next == OVER) ? 1'b0 : w_commit ? eat : r_eat_seen | eat;
         r_frame_cnt <= w_commit ? r_frame_cnt + 8'd1 : r_frame_cnt;
         r_score     <= w_score_next;
         red         <= !display_area ? 4'h0 : w_lit ? 4'hF : red_in;
         green       <= !display_area ? 4'h0 : w_lit ? 4'hF : green_in;
         blue        <= !display_area ? 4'h0 : w_lit ? 4'hF : blue_in;
         h_sync      <= h_sync_in;
         v_sync      <= v_sync_in;
      end
   end
   assign score_bcd = r_score;
   assign over      = r_state == OVER;
endmodule

// File: tb/tb_snake_score_overlay.sv
// tb_snake_score_overlay: table-driven pixel vectors plus frame sequences for score, saturation, game over and blink.
module tb_snake_score_overlay;
   logic        VGA_clk = 1'b0;
   logic        reset, display_area, h_sync_in, v_sync_in, eat, game_over;
   logic [10:0] x_count;
   logic [9:0]  y_count;
   logic [3:0]  red_in, green_in, blue_in, red, green, blue;
   logic        h_sync, v_sync, over;
   logic [11:0] score_bcd;
`ifdef SNAKE_SCORE_HIGH_EN
   logic [11:0] high_bcd;
`endif
   int n_vec = 0, n_err = 0, fc = 0;
   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic        da, hs, vs;
      logic [3:0]  r, g, b, er, eg, eb;
   } vec_t;
   vec_t sb[$];
   vec_t vt[12];
   always #5 VGA_clk = ~VGA_clk;
   snake_score_overlay dut (
      .VGA_clk(VGA_clk), .reset(reset), .x_count(x_count), .y_count(y_count),
      .display_area(display_area), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .eat(eat), .game_over(game_over),
      .red(red), .green(green), .blue(blue), .h_sync(h_sync), .v_sync(v_sync),
      .score_bcd(score_bcd),
`ifdef SNAKE_SCORE_HIGH_EN
      .high_bcd(high_bcd),
`endif
      .over(over)
   );
   function automatic vec_t mk(input int x, input int y, input logic da, input logic hs, input logic vs,
                               input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                               input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
      vec_t v;
      v.x = 11'(x); v.y = 10'(y); v.da = da; v.hs = hs; v.vs = vs;
      v.r = r; v.g = g; v.b = b; v.er = er; v.eg = eg; v.eb = eb;
      return v;
   endfunction
   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic apply(input vec_t v, input string nm);
      vec_t e;
      x_count = v.x; y_count = v.y; display_area = v.da; h_sync_in = v.hs; v_sync_in = v.vs;
      red_in = v.r; green_in = v.g; blue_in = v.b; eat = 1'b0;
      sb.push_back(v);
      @(posedge VGA_clk); #1;
      e = sb.pop_front();
      check({nm, " rgb"}, {red, green, blue}, {e.er, e.eg, e.eb});
      check({nm, " sync"}, {10'd0, h_sync, v_sync}, {10'd0, e.hs, e.vs});
   endtask
   task automatic idle(input logic e, input logic go);
      x_count = 11'd700; y_count = 10'd500; display_area = 1'b0; eat = e; game_over = go;
      @(posedge VGA_clk); #1;
   endtask
   task automatic commit(input logic e, input logic go);
      x_count = 11'd0; y_count = 10'd480; display_area = 1'b0; eat = e; game_over = go;
      @(posedge VGA_clk); #1;
      fc = (fc + 1) % 256;
   endtask
   task automatic frame(input logic e, input logic go);
      idle(e, go);
      commit(1'b0, go);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      @(posedge VGA_clk); #1;
      reset = 1'b0; fc = 0; game_over = 1'b0; eat = 1'b0;
   endtask
   initial begin
      reset = 1'b1; x_count = 11'd300; y_count = 10'd100; display_area = 1'b1;
      h_sync_in = 1'b0; v_sync_in = 1'b0; red_in = 4'h5; green_in = 4'h5; blue_in = 4'h5;
      eat = 1'b0; game_over = 1'b0;
      @(posedge VGA_clk); #1;
      check("reset rgb", {red, green, blue}, 12'h000);
      check("reset sync", {10'd0, h_sync, v_sync}, 12'h003);
      check("reset score", score_bcd, 12'h000);
      check("reset over", {11'd0, over}, 12'h000);
      reset = 1'b0;
      vt[0]  = mk(565, 21, 1, 0, 1, 4'h5, 4'h6, 4'h7, 4'hF, 4'hF, 4'hF);
      vt[1]  = mk(565, 32, 1, 1, 0, 4'h5, 4'h6, 4'h7, 4'h5, 4'h6, 4'h7);
      vt[2]  = mk(100, 100, 1, 1, 0, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5);
      vt[3]  = mk(100, 100, 0, 1, 1, 4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0);
      vt[4]  = mk(565, 21, 0, 0, 0, 4'h5, 4'h6, 4'h7, 4'h0, 4'h0, 4'h0);
      vt[5]  = mk(601, 25, 1, 1, 1, 4'h1, 4'h2, 4'h3, 4'hF, 4'hF, 4'hF);
      vt[6]  = mk(560, 20, 1, 1, 1, 4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3);
      vt[7]  = mk(575, 43, 1, 1, 1, 4'h9, 4'h8, 4'h7, 4'h9, 4'h8, 4'h7);
      vt[8]  = mk(576, 30, 1, 0, 1, 4'hA, 4'hB, 4'hC, 4'hA, 4'hB, 4'hC);
      vt[9]  = mk(594, 35, 1, 1, 0, 4'h2, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF);
      vt[10] = mk(568, 44, 1, 1, 1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4);
      vt[11] = mk(582, 21, 1, 1, 1, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
      frame(1'b0, 1'b0);
      frame(1'b0, 1'b0);
      check("idle score", score_bcd, 12'h000);
      check("idle over", {11'd0, over}, 12'h000);
      foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));
      for (int i = 0; i < 40; i++) idle(1'b1, 1'b0);
      check("pre-commit score", score_bcd, 12'h000);
      commit(1'b0, 1'b0);
      check("40 eats one point", score_bcd, 12'h001);
      apply(mk(605, 21, 1, 1, 1, 4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h6), "one a-off");
      apply(mk(614, 25, 1, 1, 1, 4'h6, 4'h6, 4'h6, 4'hF, 4'hF, 4'hF), "one b-on");
      commit(1'b1, 1'b0);
      check("eat on commit deferred", score_bcd, 12'h001);
      commit(1'b0, 1'b0);
      check("deferred eat counted", score_bcd, 12'h002);
      for (int i = 0; i < 7; i++) frame(1'b1, 1'b0);
      check("score 009", score_bcd, 12'h009);
      frame(1'b1, 1'b0);
      check("carry 010", score_bcd, 12'h010);
      for (int i = 0; i < 89; i++) frame(1'b1, 1'b0);
      check("carry 099", score_bcd, 12'h099);
      frame(1'b1, 1'b0);
      check("carry 100", score_bcd, 12'h100);
      for (int i = 0; i < 899; i++) frame(1'b1, 1'b0);
      check("score 999", score_bcd, 12'h999);
      frame(1'b1, 1'b0);
      check("saturate 999", score_bcd, 12'h999);
      do_reset();
      check("reset clears score", score_bcd, 12'h000);
      for (int i = 0; i < 41; i++) frame(1'b1, 1'b0);
      check("score 041", score_bcd, 12'h041);
      idle(1'b1, 1'b1);
      check("over before commit", {11'd0, over}, 12'h000);
      commit(1'b0, 1'b1);
      check("eat+over score", score_bcd, 12'h042);
      check("over set", {11'd0, over}, 12'h001);
      for (int i = 0; i < 70; i++) begin
         frame(1'b1, 1'b1);
         apply(mk(565, 21, 1, 1, 1, 4'h3, 4'h3, 4'h3,
                  fc[4] ? 4'h3 : 4'hF, fc[4] ? 4'h3 : 4'hF, fc[4] ? 4'h3 : 4'hF), $sformatf("blink fc%0d", fc));
      end
      check("frozen score", score_bcd, 12'h042);
      check("over held", {11'd0, over}, 12'h001);
      x_count = 11'd300; y_count = 10'd100; display_area = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0;
      red_in = 4'h5; green_in = 4'h5; blue_in = 4'h5; reset = 1'b1;
      @(posedge VGA_clk); #1;
      check("midline reset score", score_bcd, 12'h000);
      check("midline reset over", {11'd0, over}, 12'h000);
      check("midline reset rgb", {red, green, blue}, 12'h000);
      check("midline reset sync", {10'd0, h_sync, v_sync}, 12'h003);
      reset = 1'b0; fc = 0; game_over = 1'b0;
      apply(mk(300, 100, 1, 0, 0, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5), "post-reset pass");
      apply(mk(300, 100, 0, 1, 1, 4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0), "post-reset blank");
      commit(1'b0, 1'b0);
      check("pending eat lost", score_bcd, 12'h000);
`ifdef SNAKE_SCORE_HIGH_EN
      check("high reset", high_bcd, 12'h000);
      for (int i = 0; i < 7; i++) frame(1'b1, 1'b0);
      frame(1'b0, 1'b1);
      check("high 007", high_bcd, 12'h007);
      apply(mk(565, 51, 1, 1, 1, 4'h2, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF), "high row a");
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
